// File: rtl/ysyx_22050854_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// mstatus field positions, cause codes, sequencer states and mstatus update helpers.
package ysyx_22050854_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  localparam logic [63:0] CAUSE_MTIMER = {1'b1, 63'd7};
  localparam logic [3:0]  CAUSE_ECALL_M = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E_SAVE,
    S_E_STATUS,
    S_M_STATUS,
    S_M_EPC,
    S_REDIRECT
  } trap_state_e;

  function automatic logic [63:0] mstatus_enter(input logic [63:0] st);
    logic [63:0] r;
    r                = st;
    r[MPIE_BIT]      = st[MIE_BIT];
    r[MIE_BIT]       = 1'b0;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mstatus_mret(input logic [63:0] st);
    logic [63:0] r;
    r           = st;
    r[MIE_BIT]  = st[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22050854_irq_holdoff.sv
// Loadable down-counter that masks the timer interrupt for HOLDOFF cycles after a load.
// Latency: masked rises the cycle after load; no backpressure.
module ysyx_22050854_irq_holdoff #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic masked
);

  localparam int W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(HOLDOFF);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign masked = (cnt_q != '0);

endmodule

// File: rtl/ysyx_22050854_trap_ctrl.sv
// Trap sequencer: exception/irq entry and mret over the CSR file ports, then a PC redirect.
// Latency: 3 cycles accept->redirect; requests are level-held and only accepted in IDLE.
import ysyx_22050854_trap_ctrl_pkg::*;

module ysyx_22050854_trap_ctrl #(
  parameter int unsigned IRQ_HOLDOFF = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [63:0] exc_pc,
  output logic        exc_ready,
  input  logic        mret_valid,
  output logic        mret_ready,
  input  logic        irq,
  input  logic [63:0] irq_pc,
  input  logic        csr_wreq,
  input  logic [11:0] csr_waddr,
  input  logic [63:0] csr_wdata,
  input  logic        csr_rreq,
  input  logic [11:0] csr_raddr,
  output logic        csr_gnt,
  output logic        wen,
  output logic [11:0] waddr1,
  output logic [63:0] wdata1,
  output logic        wen2,
  output logic [11:0] waddr2,
  output logic [63:0] wdata2,
  output logic        ren,
  output logic [11:0] raddr,
  input  logic [63:0] rdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  trap_state_e state_q;
  logic [63:0] pc_q;
  logic [63:0] cause_q;
  logic [63:0] st_q;
  logic [63:0] target_q;
  logic        irq_q;
  logic        masked;
  logic        idle;
  logic        take_irq;
  logic        take_exc;
  logic        take_mret;
  logic        pass;

  ysyx_22050854_irq_holdoff #(.HOLDOFF(IRQ_HOLDOFF)) u_holdoff (
    .clock  (clock),
    .reset  (reset),
    .load   ((state_q == S_REDIRECT) && irq_q),
    .masked (masked)
  );

  assign idle      = (state_q == S_IDLE);
  assign take_irq  = idle && irq && !masked;
  assign take_exc  = idle && !take_irq && exc_valid;
  assign take_mret = idle && !take_irq && !exc_valid && mret_valid;
  assign pass      = idle && !take_irq && !exc_valid && !mret_valid;

  assign exc_ready      = take_exc;
  assign mret_ready     = take_mret;
  assign busy           = !idle;
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = target_q;

  always_comb begin
    csr_gnt = 1'b0;
    wen     = 1'b0;
    waddr1  = '0;
    wdata1  = '0;
    wen2    = 1'b0;
    waddr2  = '0;
    wdata2  = '0;
    ren     = 1'b0;
    raddr   = '0;
    case (state_q)
      S_IDLE: begin
        if (pass) begin
          csr_gnt = csr_wreq | csr_rreq;
          wen     = csr_wreq;
          waddr1  = csr_waddr;
          wdata1  = csr_wdata;
          ren     = csr_rreq;
          raddr   = csr_raddr;
        end
      end
      S_E_SAVE: begin
        wen    = 1'b1;
        waddr1 = CSR_MEPC;
        wdata1 = pc_q;
        wen2   = 1'b1;
        waddr2 = CSR_MCAUSE;
        wdata2 = cause_q;
        ren    = 1'b1;
        raddr  = CSR_MSTATUS;
      end
      S_E_STATUS: begin
        wen    = 1'b1;
        waddr1 = CSR_MSTATUS;
        wdata1 = mstatus_enter(st_q);
        ren    = 1'b1;
        raddr  = CSR_MTVEC;
      end
      S_M_STATUS: begin
        // Read-modify-write in one cycle relies on the CSR file's combinational read.
        wen    = 1'b1;
        waddr1 = CSR_MSTATUS;
        wdata1 = mstatus_mret(rdata);
        ren    = 1'b1;
        raddr  = CSR_MSTATUS;
      end
      S_M_EPC: begin
        ren   = 1'b1;
        raddr = CSR_MEPC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      st_q     <= '0;
      target_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take_irq) begin
            pc_q    <= irq_pc;
            cause_q <= CAUSE_MTIMER;
            irq_q   <= 1'b1;
            state_q <= S_E_SAVE;
          end else if (take_exc) begin
            pc_q    <= exc_pc;
            cause_q <= {60'd0, exc_cause};
            irq_q   <= 1'b0;
            state_q <= S_E_SAVE;
          end else if (take_mret) begin
            irq_q   <= 1'b0;
            state_q <= S_M_STATUS;
          end
        end
        S_E_SAVE: begin
          st_q    <= rdata;
          state_q <= S_E_STATUS;
        end
        S_E_STATUS: begin
          target_q <= rdata & ~64'd3;
          state_q  <= S_REDIRECT;
        end
        S_M_STATUS: state_q <= S_M_EPC;
        S_M_EPC: begin
          target_q <= rdata;
          state_q  <= S_REDIRECT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22050854_trap_ctrl.md
# ysyx_22050854_trap_ctrl

Trap sequencer for the NPC core's machine-mode CSR file. It accepts synchronous exceptions, `mret` and the timer interrupt, and sequences the CSR reads and writes each one needs (mepc, mcause, mstatus, mtvec) over several cycles. It then issues a PC redirect to the fetch stage. It owns the CSR file's two write ports and single read port, and arbitrates them against ordinary pipeline CSR instructions.

## Interface
- `IRQ_HOLDOFF`, 2: cycles after an interrupt redirect during which `irq` is ignored. This covers the CSR file's two-register mip→timer_interrupt delay.
- `clock`  in  1  core clock
- `reset`  in  1  asynchronous, active-low: asserted at 0, deasserted synchronously by the top level
- `exc_valid`  in  1  synchronous exception request; held until `exc_ready`
- `exc_cause`  in  4  exception code (11 = ecall-M)
- `exc_pc`  in  64  PC of the faulting instruction
- `exc_ready`  out  1  exception accepted this cycle
- `mret_valid`  in  1  mret request; held until `mret_ready`
- `mret_ready`  out  1  mret accepted this cycle
- `irq`  in  1  timer_interrupt from the CSR file (level)
- `irq_pc`  in  64  PC of the next unretired instruction
- `csr_wreq`, `csr_waddr[11:0]`, `csr_wdata[63:0]`  in  pipeline CSR write request
- `csr_rreq`, `csr_raddr[11:0]`  in  pipeline CSR read request
- `csr_gnt`  out  1  pipeline CSR access granted this cycle
- `wen`, `waddr1[11:0]`, `wdata1[63:0]`, `wen2`, `waddr2[11:0]`, `wdata2[63:0]`  out  to CSR file write ports
- `ren`, `raddr[11:0]`  out  to CSR file read port
- `rdata`  in  64  CSR file read data (combinational)
- `busy`  out  1  sequence in progress; stalls the pipeline
- `redirect_valid`  out  1  one-cycle pulse
- `redirect_pc`  out  64  redirect target

## Operation
- States: IDLE, E_SAVE, E_STATUS, M_STATUS, M_EPC, REDIRECT.
- IDLE priority: irq (outside holdoff) > exc_valid > mret_valid > pipeline CSR access.
  - Accepting irq or an exception latches PC and cause. Interrupt cause = {1, 63'd7}; exception cause = zero-extended exc_cause. Next state is E_SAVE.
  - Accepting mret → M_STATUS.
  - Otherwise pipeline signals pass straight through to wen/waddr1/wdata1 and ren/raddr. `csr_gnt` = csr_wreq | csr_rreq; wen2 = 0.
- E_SAVE: wen = 1 writes mepc (0x341) = latched PC; wen2 = 1 writes mcause (0x342). Read mstatus (0x300) and capture it into `st_q`.
- E_STATUS: write mstatus = st_q with MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11. Read mtvec (0x305) and capture target = rdata & ~3.
- M_STATUS: read mstatus; write it back the same cycle with MIE ← MPIE, MPIE ← 1.
- M_EPC: read mepc and capture it as the target.
- REDIRECT: redirect_valid = 1 with redirect_pc = target, then → IDLE. An interrupt entry also loads the holdoff counter with IDLE_HOLDOFF… specifically with `IRQ_HOLDOFF`.
- busy = 1 in every non-IDLE state. csr_gnt = 0 while busy.
- Requests arriving while busy are not lost. They are level-held by the requester and re-evaluated in IDLE.

## Timing
- Reset (async, 0): state IDLE, holdoff = 0, st_q = 0, target = 0. All outputs 0, except pass-through outputs, which follow their inputs (0 when idle inputs are 0).
- Trap entry: accept at cycle 0 → E_SAVE (1) → E_STATUS (2) → REDIRECT pulse (3) → IDLE (4). Latency is 3 cycles from accept to redirect.
- mret: accept (0) → M_STATUS (1) → M_EPC (2) → REDIRECT (3).
- exc_ready / mret_ready are single-cycle combinational pulses, asserted only in IDLE.
- Holdoff counts down once per cycle. irq is masked while the counter is nonzero. Exceptions and mret are unaffected by holdoff.
- Simultaneous irq + exc_valid: irq is taken and exc_ready stays 0. The exception is re-presented after the handler's mret.
- Reset asserted mid-sequence aborts immediately: no redirect, and partial CSR writes are retained.

## Structure
- Shared package: CSR address constants (MSTATUS, MTVEC, MEPC, MCAUSE), mstatus bit indices (MIE = 3, MPIE = 7, MPP = 12:11), cause codes, state enum.
- Optional sub-module `ysyx_22050854_irq_holdoff`: a loadable down-counter with a `masked` output. Everything else stays in one module.

## Test plan
- Exception: exc_valid, cause 11, pc 0x8000_0100, mstatus = 0x8, mtvec = 0x8000_0400.
  - Expected: mepc = 0x8000_0100, mcause = 11, mstatus = 0x1880.
  - redirect 0x8000_0400 exactly 3 cycles after exc_ready.
- Timer: irq, irq_pc 0x8000_0200.
  - Expected: mcause = 0x8000_0000_0000_0007.
  - irq held high for 2 cycles after the redirect is ignored; a third high cycle is accepted.
- mret: mstatus = 0x1880, mepc = 0x8000_0104 → mstatus = 0x1888, redirect 0x8000_0104 at cycle 3.
- Arbitration: csr_wreq to mtvec asserted during E_SAVE → csr_gnt = 0 until IDLE, then the write lands with wen = 1 and wen2 = 0.
- Priority: irq and exc_valid in the same cycle → interrupt taken, exc_ready = 0; after mret the exception is accepted.
- Reset low during E_STATUS → busy = 0 and state IDLE immediately, no redirect_valid pulse.
